blackjack_round_fsm: RTL

- Round controller for the FPGA blackjack game; the FSM-side counterpart of the currency system.
- Consumes `bet_confirmed` and `current_bet`, and produces `game_state_idle`, `game_won` and `game_push`.
- Requests cards from the deck/shuffler block and runs one round: initial deal, player hit/stand, dealer draw, resolution.
- Drives hand totals to the display logic.

---
 rtl/blackjack_round_fsm.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/blackjack_round_fsm.sv
// Round controller for one blackjack hand: deal, player hit/stand, dealer draw, resolution.
// Define DEALER_HITS_SOFT17_EN to make the dealer draw on a soft total equal to DEALER_STAND_TOTAL (H17).
module blackjack_round_fsm #(
    parameter int unsigned RESULT_HOLD_CYCLES = 50000000,
    parameter int unsigned DEALER_STAND_TOTAL = 17
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       bet_confirmed,
    input  logic [7:0] current_bet,
    input  logic       hit,
    input  logic       stand,
    input  logic       card_valid,
    input  logic [3:0] card_rank,
    output logic       card_req,
    output logic       game_state_idle,
    output logic       game_won,
    output logic       game_push,
    output logic       game_lost,
    output logic [4:0] player_total,
    output logic [4:0] dealer_total,
    output logic [7:0] round_bet,
    output logic [3:0] dbg_state
);

    typedef enum logic [3:0] {
        S_IDLE, S_DEAL_P1, S_DEAL_D1, S_DEAL_P2, S_DEAL_D2, S_PLAYER_TURN,
        S_PLAYER_DRAW, S_DEALER_TURN, S_DEALER_DRAW, S_RESOLVE, S_RESULT
    } state_t;

    localparam int unsigned     CNT_W    = (RESULT_HOLD_CYCLES > 1) ? $clog2(RESULT_HOLD_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(RESULT_HOLD_CYCLES - 1);
    localparam logic [5:0]      STAND_T  = 6'(DEALER_STAND_TOTAL);

    // Best total: an ace counts 11 when that does not bust the hand.
    function automatic logic [5:0] best_of(input logic [5:0] hard, input logic [4:0] aces);
        return ((aces != 5'd0) && (hard <= 6'd11)) ? hard + 6'd10 : hard;
    endfunction

    function automatic logic [4:0] sat5(input logic [5:0] v);
        return (v > 6'd31) ? 5'd31 : v[4:0];
    endfunction

    state_t           state_q, state_d;
    logic [5:0]       p_hard_q, p_hard_d, d_hard_q, d_hard_d;
    logic [4:0]       p_aces_q, p_aces_d, d_aces_q, d_aces_d;
    logic [7:0]       bet_q, bet_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ack_q, ack_d;
    logic             won_q, won_d, push_q, push_d, lost_q, lost_d;

    logic [5:0] card_v;
    logic       card_ace;
    logic       card_state, accept;
    logic [5:0] p_best, d_best, p_hard_new, d_hard_new;
    logic [4:0] p_aces_new, d_aces_new;
    logic       d_draw;

    always_comb begin
        card_ace = (card_rank == 4'd1);
        if (card_rank == 4'd1)
            card_v = 6'd1;
        else if ((card_rank >= 4'd2) && (card_rank <= 4'd10))
            card_v = {2'b00, card_rank};
        else
            card_v = 6'd10;
    end

    assign p_best     = best_of(p_hard_q, p_aces_q);
    assign d_best     = best_of(d_hard_q, d_aces_q);
    assign p_hard_new = p_hard_q + card_v;
    assign d_hard_new = d_hard_q + card_v;
    assign p_aces_new = p_aces_q + {4'b0000, card_ace};
    assign d_aces_new = d_aces_q + {4'b0000, card_ace};

`ifdef DEALER_HITS_SOFT17_EN
    logic d_soft;
    assign d_soft = (d_aces_q != 5'd0) && (d_hard_q <= 6'd11);
    assign d_draw = (d_best < STAND_T) || (d_soft && (d_best == STAND_T));
`else
    assign d_draw = (d_best < STAND_T);
`endif

    // ack_q forces a one-cycle gap after every accepted card so each deal is its own handshake.
    assign card_state = (state_q == S_DEAL_P1) || (state_q == S_DEAL_D1) ||
                        (state_q == S_DEAL_P2) || (state_q == S_DEAL_D2) ||
                        (state_q == S_PLAYER_DRAW) || (state_q == S_DEALER_DRAW);
    assign card_req   = card_state && !ack_q;
    assign accept     = card_req && card_valid;

    always_comb begin
        state_d  = state_q;
        p_hard_d = p_hard_q;
        p_aces_d = p_aces_q;
        d_hard_d = d_hard_q;
        d_aces_d = d_aces_q;
        bet_d    = bet_q;
        cnt_d    = cnt_q;
        ack_d    = 1'b0;
        won_d    = 1'b0;
        push_d   = 1'b0;
        lost_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bet_confirmed) begin
                    state_d  = S_DEAL_P1;
                    p_hard_d = '0;
                    p_aces_d = '0;
                    d_hard_d = '0;
                    d_aces_d = '0;
                    bet_d    = current_bet;
                end
            end
            S_DEAL_P1, S_DEAL_P2, S_PLAYER_DRAW: begin
                if (accept) begin
                    p_hard_d = p_hard_new;
                    p_aces_d = p_aces_new;
                    ack_d    = 1'b1;
                    if (state_q == S_DEAL_P1)
                        state_d = S_DEAL_D1;
                    else if (state_q == S_DEAL_P2)
                        state_d = S_DEAL_D2;
                    else if (best_of(p_hard_new, p_aces_new) > 6'd21)
                        state_d = S_RESOLVE;
                    else
                        state_d = S_PLAYER_TURN;
                end
            end
            S_DEAL_D1, S_DEAL_D2, S_DEALER_DRAW: begin
                if (accept) begin
                    d_hard_d = d_hard_new;
                    d_aces_d = d_aces_new;
                    ack_d    = 1'b1;
                    if (state_q == S_DEAL_D1)
                        state_d = S_DEAL_P2;
                    else if (state_q == S_DEAL_D2)
                        state_d = S_PLAYER_TURN;
                    else
                        state_d = S_DEALER_TURN;
                end
            end
            S_PLAYER_TURN: begin
                if ((p_best == 6'd21) || stand)
                    state_d = S_DEALER_TURN;
                else if (hit)
                    state_d = S_PLAYER_DRAW;
            end
            S_DEALER_TURN: begin
                state_d = d_draw ? S_DEALER_DRAW : S_RESOLVE;
            end
            S_RESOLVE: begin
                state_d = S_RESULT;
                cnt_d   = '0;
                if (p_best > 6'd21)
                    lost_d = 1'b1;
                else if (d_best > 6'd21)
                    won_d = 1'b1;
                else if (p_best > d_best)
                    won_d = 1'b1;
                else if (p_best == d_best)
                    push_d = 1'b1;
                else
                    lost_d = 1'b1;
            end
            S_RESULT: begin
                if (cnt_q == CNT_LAST)
                    state_d = S_IDLE;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            p_hard_q <= '0;
            p_aces_q <= '0;
            d_hard_q <= '0;
            d_aces_q <= '0;
            bet_q    <= '0;
            cnt_q    <= '0;
            ack_q    <= 1'b0;
            won_q    <= 1'b0;
            push_q   <= 1'b0;
            lost_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            p_hard_q <= p_hard_d;
            p_aces_q <= p_aces_d;
            d_hard_q <= d_hard_d;
            d_aces_q <= d_aces_d;
            bet_q    <= bet_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            won_q    <= won_d;
            push_q   <= push_d;
            lost_q   <= lost_d;
        end
    end

    assign game_state_idle = (state_q == S_IDLE);
    assign game_won        = won_q;
    assign game_push       = push_q;
    assign game_lost       = lost_q;
    assign player_total    = sat5(p_best);
    assign dealer_total    = sat5(d_best);
    assign round_bet       = bet_q;
    assign dbg_state       = state_q;

endmodule
